// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage hazard controller signal bundle
//
// Purpose : groups the comparator inputs, redirect/memory handshake and the
//           pipeline enable/flush outputs of hazard_ctrl.
// Ports   : master - pipeline side: drives Rs/Rt/useRs/useRt/RtEx/isLoad/
//                    branchTaken/memReady, receives enables and flushes.
//           slave  - hazard_ctrl side: the mirror of master.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] Rs;
    logic [REG_W-1:0] Rt;
    logic             useRs;
    logic             useRt;
    logic [REG_W-1:0] RtEx;
    logic             isLoad;
    logic             branchTaken;
    logic             memReady;
    logic             pcEnable;
    logic             ifEnable;
    logic             controlEnable;
    logic             exEnable;
    logic             ifFlush;
    logic             idFlush;
    logic             stallActive;

    modport master (
        output Rs, Rt, useRs, useRt, RtEx, isLoad, branchTaken, memReady,
        input  pcEnable, ifEnable, controlEnable, exEnable, ifFlush, idFlush, stallActive
    );

    modport slave (
        input  Rs, Rt, useRs, useRt, RtEx, isLoad, branchTaken, memReady,
        output pcEnable, ifEnable, controlEnable, exEnable, ifFlush, idFlush, stallActive
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, redirect flush and memory-wait freeze control
//
// Purpose : drives PC / IF-ID / ID-EX enables and IF-ID / ID-EX flushes for the
//           five-stage pipeline. Load-use stalls last LOAD_LAT cycles, taken
//           redirects squash IF/ID for FLUSH_CYCLES cycles, memReady=0 freezes
//           everything. Outputs are combinational from inputs and state.
// Ports   : clk, reset (async active-low), hz (hazard_ctrl_if.slave).
//           With HAZARD_STATS_EN defined: statsClear in, loadStallCount,
//           flushCount, memWaitCount (32-bit saturating) out.
// Macro   : HAZARD_STATS_EN
module hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HAZARD_STATS_EN
    input  logic        statsClear,
    output logic [31:0] loadStallCount,
    output logic [31:0] flushCount,
    output logic [31:0] memWaitCount,
`endif
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {ST_RUN, ST_LSTALL, ST_FLUSH, ST_MWAIT} state_t;

    localparam logic [REG_W-1:0] ZERO_REG  = '0;
    localparam logic [2:0]       CNT_LOAD  = 3'(LOAD_LAT - 1);
    localparam logic [2:0]       CNT_FLUSH = 3'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_cnt;

    logic w_hazard;
    logic w_freeze;
    logic w_lstall;
    logic w_flush;

    assign w_hazard = hz.isLoad && (hz.RtEx != ZERO_REG) &&
                      ((hz.useRs && (hz.Rs == hz.RtEx)) ||
                       (hz.useRt && (hz.Rt == hz.RtEx)));

    // MWAIT only marks a freeze entered from RUN; once memory is ready it
    // behaves exactly like RUN.
    always_comb begin
        w_freeze          = 1'b0;
        w_lstall          = 1'b0;
        w_flush           = 1'b0;
        hz.pcEnable       = 1'b1;
        hz.ifEnable       = 1'b1;
        hz.controlEnable  = 1'b1;
        hz.exEnable       = 1'b1;
        hz.ifFlush        = 1'b0;
        hz.idFlush        = 1'b0;
        if (reset) begin
            if (!hz.memReady) begin
                w_freeze         = 1'b1;
                hz.pcEnable      = 1'b0;
                hz.ifEnable      = 1'b0;
                hz.controlEnable = 1'b0;
                hz.exEnable      = 1'b0;
            end else if (hz.branchTaken) begin
                w_flush     = 1'b1;
                hz.ifFlush  = 1'b1;
                hz.idFlush  = 1'b1;
            end else if (r_state == ST_FLUSH) begin
                w_flush     = 1'b1;
                hz.ifFlush  = 1'b1;
            end else if ((r_state == ST_LSTALL) || w_hazard) begin
                w_lstall         = 1'b1;
                hz.pcEnable      = 1'b0;
                hz.ifEnable      = 1'b0;
                hz.controlEnable = 1'b0;
            end
        end
        hz.stallActive = w_freeze || w_flush || w_lstall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else if (!hz.memReady) begin
            // Frozen: hold count, only remember that the freeze began in RUN.
            if (r_state == ST_RUN) r_state <= ST_MWAIT;
        end else if (hz.branchTaken) begin
            // A stall in progress belongs to a wrong-path instruction; drop it.
            if (FLUSH_CYCLES > 1) begin
                r_state <= ST_FLUSH;
                r_cnt   <= CNT_FLUSH;
            end else begin
                r_state <= ST_RUN;
                r_cnt   <= 3'd0;
            end
        end else if ((r_state == ST_FLUSH) || (r_state == ST_LSTALL)) begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) r_state <= ST_RUN;
        end else if (w_hazard && (LOAD_LAT > 1)) begin
            r_state <= ST_LSTALL;
            r_cnt   <= CNT_LOAD;
        end else begin
            r_state <= ST_RUN;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loadStallCount <= 32'd0;
            flushCount     <= 32'd0;
            memWaitCount   <= 32'd0;
        end else if (statsClear) begin
            loadStallCount <= 32'd0;
            flushCount     <= 32'd0;
            memWaitCount   <= 32'd0;
        end else begin
            if (w_lstall && (loadStallCount != 32'hFFFF_FFFF)) loadStallCount <= loadStallCount + 32'd1;
            if (w_flush  && (flushCount     != 32'hFFFF_FFFF)) flushCount     <= flushCount + 32'd1;
            if (w_freeze && (memWaitCount   != 32'hFFFF_FFFF)) memWaitCount   <= memWaitCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] t_rs = '0, t_rt = '0, t_rtex = '0;
    logic       t_urs = 1'b0, t_urt = 1'b0, t_ld = 1'b0, t_br = 1'b0, t_mr = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    hazard_ctrl_if #(.REG_W(5)) ifa ();
    hazard_ctrl_if #(.REG_W(5)) ifb ();

    assign ifa.Rs = t_rs;   assign ifb.Rs = t_rs;
    assign ifa.Rt = t_rt;   assign ifb.Rt = t_rt;
    assign ifa.RtEx = t_rtex; assign ifb.RtEx = t_rtex;
    assign ifa.useRs = t_urs; assign ifb.useRs = t_urs;
    assign ifa.useRt = t_urt; assign ifb.useRt = t_urt;
    assign ifa.isLoad = t_ld; assign ifb.isLoad = t_ld;
    assign ifa.branchTaken = t_br; assign ifb.branchTaken = t_br;
    assign ifa.memReady = t_mr; assign ifb.memReady = t_mr;

`ifdef HAZARD_STATS_EN
    logic        stats_clear = 1'b0;
    logic [31:0] a_ls, a_fl, a_mw, b_ls, b_fl, b_mw;
`endif

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .FLUSH_CYCLES(1)) u_a (
        .clk(clk),
        .reset(reset),
`ifdef HAZARD_STATS_EN
        .statsClear(stats_clear),
        .loadStallCount(a_ls),
        .flushCount(a_fl),
        .memWaitCount(a_mw),
`endif
        .hz(ifa)
    );

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(2)) u_b (
        .clk(clk),
        .reset(reset),
`ifdef HAZARD_STATS_EN
        .statsClear(stats_clear),
        .loadStallCount(b_ls),
        .flushCount(b_fl),
        .memWaitCount(b_mw),
`endif
        .hz(ifb)
    );

    // {pcEnable, ifEnable, controlEnable, exEnable, ifFlush, idFlush, stallActive}
    wire [6:0] obs_a = {ifa.pcEnable, ifa.ifEnable, ifa.controlEnable, ifa.exEnable,
                        ifa.ifFlush, ifa.idFlush, ifa.stallActive};
    wire [6:0] obs_b = {ifb.pcEnable, ifb.ifEnable, ifb.controlEnable, ifb.exEnable,
                        ifb.ifFlush, ifb.idFlush, ifb.stallActive};

    localparam logic [6:0] O_RUN = 7'b1111_00_0;
    localparam logic [6:0] O_STL = 7'b0001_00_1;
    localparam logic [6:0] O_FRZ = 7'b0000_00_1;
    localparam logic [6:0] O_BR  = 7'b1111_11_1;
    localparam logic [6:0] O_FL  = 7'b1111_10_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then check both instances 1ns later.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rtex, input logic ld,
                        input logic br, input logic mr,
                        input logic [6:0] exp_a, input logic [6:0] exp_b);
        @(negedge clk);
        t_rs = rs; t_urs = urs; t_rt = rt; t_urt = urt;
        t_rtex = rtex; t_ld = ld; t_br = br; t_mr = mr;
        #1;
        chk({tag, "_a"}, 32'(obs_a), 32'(exp_a));
        chk({tag, "_b"}, 32'(obs_b), 32'(exp_b));
    endtask

    initial begin
        // Reset forces the idle output pattern even with a hazard and memReady=0.
        step("rst_force", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_RUN, O_RUN);
        @(negedge clk);
        reset = 1'b1;
        step("idle",      5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Load-use on Rs: LOAD_LAT=1 stalls 1 cycle, LOAD_LAT=3 stalls 3.
        step("lu_c1",     5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, O_STL, O_STL);
        step("lu_c2",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("lu_c3",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("lu_done",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Filtering: register 0, and an unused Rt match.
        step("flt_r0",    5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, O_RUN, O_RUN);
        step("flt_nuse",  5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, O_RUN, O_RUN);
        step("flt_noload",5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Load-use on Rt with a different width pattern (31).
        step("rt_c1",     5'd3, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, O_STL, O_STL);
        step("rt_c2",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("rt_c3",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("rt_done",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Redirect together with a hazard: redirect wins.
        step("br_c1",     5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, O_BR,  O_BR);
        step("br_c2",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_FL);
        step("br_done",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Freeze at stall cycle 2 for 2 cycles; the stall resumes afterwards.
        step("fz_c1",     5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, O_STL, O_STL);
        step("fz_w1",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_FRZ, O_FRZ);
        step("fz_w2",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_FRZ, O_FRZ);
        step("fz_c2",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("fz_c3",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_STL);
        step("fz_done",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Redirect during a multi-cycle stall abandons the stall.
        step("ab_c1",     5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, O_STL, O_STL);
        step("ab_br",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_BR,  O_BR);
        step("ab_fl",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_FL);
        step("ab_done",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        // Reset asserted during flush cycle 1 aborts immediately.
        step("rs_br",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_BR,  O_BR);
        step("rs_fl",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_FL);
        #1 reset = 1'b0;
        #1;
        chk("rs_abort_a", 32'(obs_a), 32'(O_RUN));
        chk("rs_abort_b", 32'(obs_b), 32'(O_RUN));
`ifdef HAZARD_STATS_EN
        chk("st_ls_b", b_ls, 32'd0);
        chk("st_fl_b", b_fl, 32'd0);
        chk("st_mw_b", b_mw, 32'd0);
        chk("st_ls_a", a_ls, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step("rs_after",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RUN, O_RUN);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage pipeline. It generalises load-use detection to a configurable load latency and adds register-zero filtering and source-use qualification. It also adds branch/jump flush sequencing over a configurable number of wrong-path slots, and whole-pipeline freeze on a data-memory wait handshake. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables plus flush controls for IF/ID and ID/EX.

## Interface
- REG_W, 5: register-specifier width.
- LOAD_LAT, 1: load-use stall cycles per hazard (1..7).
- FLUSH_CYCLES, 1: cycles of IF/ID squash after a taken redirect (1..7).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Rs, Rt  in  REG_W  source specifiers of the instruction in ID.
- useRs, useRt  in  1  the ID instruction actually reads Rs / Rt.
- RtEx  in  REG_W  destination of the instruction in EX.
- isLoad  in  1  the EX instruction is a load.
- branchTaken  in  1  one-cycle pulse: redirect resolved this cycle.
- memReady  in  1  data memory can complete this cycle; 0 freezes the pipe.
- pcEnable, ifEnable  out  1  PC / IF-ID register load enables.
- controlEnable  out  1  0 forces ID/EX control to a bubble.
- exEnable  out  1  ID/EX, EX/MEM and MEM/WB load enable.
- ifFlush, idFlush  out  1  synchronous clear of IF/ID / ID/EX.
- stallActive  out  1  any stall, flush or freeze in effect.

## Operation
- State machine has four states: RUN, LSTALL, FLUSH and MWAIT. A 3-bit down-counter `cnt` supports the multi-cycle states.
- A hazard exists when all of these hold: isLoad=1, RtEx≠0, and either (useRs and Rs==RtEx) or (useRt and Rt==RtEx).
- Priority each cycle, highest first:
  1. memReady=0.
  2. branchTaken=1.
  3. A pending count in the current state.
  4. A new hazard.
- memReady=0, from any state:
  - Outputs: all enables 0, flushes 0.
  - State and cnt are held; the machine records MWAIT only when the state is RUN.
  - branchTaken and hazard inputs are ignored. Producers hold them stable while frozen.
- branchTaken=1 with memReady=1:
  - Outputs this cycle: ifFlush=1, idFlush=1, all enables 1.
  - Any LSTALL in progress is abandoned, because the stalled instruction is wrong-path.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- FLUSH: ifFlush=1, idFlush=0, all enables 1. cnt decrements each cycle; at cnt==1 return to RUN.
- Hazard detected in RUN:
  - Outputs this cycle: pcEnable=ifEnable=controlEnable=0, exEnable=1.
  - If LOAD_LAT>1: go to LSTALL with cnt=LOAD_LAT-1. Otherwise stay in RUN.
- LSTALL: same outputs as the hazard cycle, regardless of comparator inputs. cnt decrements each cycle; at cnt==1 return to RUN.
- RUN with no event: all enables 1, flushes 0.
- stallActive = NOT (all enables 1 AND both flushes 0).
- Specifier compare is exact REG_W-bit equality. Register 0 never produces a hazard.

## Timing
- Detection is combinational. Enables and flushes respond in the same cycle as the inputs, with no added latency.
- A load-use hazard costs exactly LOAD_LAT bubbles.
- A redirect costs exactly FLUSH_CYCLES cycles of ifFlush, plus one cycle of idFlush.
- State and cnt update on the rising clk edge. A freeze extends a sequence by the freeze length without shortening it.
- Reset is asynchronous: state=RUN, cnt=0.
  - While reset=0, outputs are forced to: pcEnable=ifEnable=controlEnable=exEnable=1, ifFlush=idFlush=0, stallActive=0, regardless of inputs.
  - Reset asserted mid-stall or mid-flush aborts the sequence immediately.
- On reset release the first edge starts in RUN.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds three 32-bit saturating counters, loadStallCount, flushCount and memWaitCount, as outputs.
  - Each counter increments on every clock in which its corresponding condition drives the outputs.
  - Adds input statsClear, which is a synchronous clear to 0 and has priority over increment.
  - Reset clears all counters to 0.
- HAZARD_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Load-use, LOAD_LAT=1: isLoad=1, RtEx=5, Rs=5, useRs=1 for one cycle, then the comparator clears.
  - Required: pcEnable/ifEnable/controlEnable=0 for exactly 1 cycle, exEnable=1 throughout.
- Load-use, LOAD_LAT=3: same stimulus.
  - Required: stall held 3 cycles even though the hazard input drops after cycle 1, then RUN.
- Filtering: RtEx=0 with Rs=0, and separately Rt==RtEx=7 with useRt=0.
  - Required: no stall in either case.
- Redirect, FLUSH_CYCLES=2: branchTaken pulse in the same cycle as a load-use hazard.
  - Required: ifFlush=1 for 2 cycles, idFlush=1 for 1 cycle, no stall, enables 1.
- Freeze mid-stall: LOAD_LAT=3, memReady=0 for 2 cycles starting at stall cycle 2.
  - Required: all enables 0 during the freeze, then 2 more stall cycles (5 cycles total with stallActive=1).
- Reset abort: assert reset=0 at flush cycle 1.
  - Required: ifFlush drops immediately and enables go to 1.
  - With HAZARD_STATS_EN, counters read 0 after reset.
